// File: rtl/bus_ts_fifo.sv
// bus_ts_fifo: per-terminal outbound queue feeding the data bus.
// Every entry stores the packet together with the free-running cycle count
// sampled at push time. The popped word is shown with its push timestamp, so
// the consumer gets an exact send time.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset
//   push_i       write strobe; d_push_i is the packet to enqueue
//   pop_i        read strobe from the bus
//   d_pop_o      head packet (show-ahead), 0 while empty
//   ts_pop_o     push timestamp of the head packet, 0 while empty
//   pndng_o      FIFO non-empty
//   full_o       FIFO holds profundidad entries
//   count_o      occupancy
//   overflow_o   sticky: a push was rejected
//   underflow_o  sticky: a pop was issued while empty
//   bad_id_o     sticky: a packet with an illegal destination was pushed
//   clr_flags_i  synchronous clear of the sticky flags (a same-cycle set wins)
//   ts_now_o     current timestamp counter
module bus_ts_fifo #(
    parameter int unsigned width       = 32,
    parameter int unsigned profundidad = 16,
    parameter int unsigned ts_width    = 32,
    parameter int unsigned drivers     = 2,
    parameter logic [7:0]  broadcast   = 8'hFF
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             push_i,
    input  logic [width-1:0]                 d_push_i,
    input  logic                             pop_i,
    output logic [width-1:0]                 d_pop_o,
    output logic [ts_width-1:0]              ts_pop_o,
    output logic                             pndng_o,
    output logic                             full_o,
    output logic [$clog2(profundidad):0]     count_o,
    output logic                             overflow_o,
    output logic                             underflow_o,
    output logic                             bad_id_o,
    input  logic                             clr_flags_i,
    output logic [ts_width-1:0]              ts_now_o
);

    localparam int unsigned PtrW   = $clog2(profundidad);
    localparam int unsigned CntW   = PtrW + 1;
    localparam logic [7:0]  NumDrv = 8'(drivers);

    logic [width-1:0]    data_mem_q [profundidad];
    logic [ts_width-1:0] ts_mem_q   [profundidad];

    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [ts_width-1:0] ts_q, ts_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                bad_id_q, bad_id_d;

    logic       empty, full, push_ok, pop_ok;
    logic [7:0] dest;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(profundidad));
    assign dest  = d_push_i[width-1 -: 8];

    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // accepted whenever it is paired with a pop.
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_i);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ts_d        = ts_q + ts_width'(1);
        overflow_d  = overflow_q & ~clr_flags_i;
        underflow_d = underflow_q & ~clr_flags_i;
        bad_id_d    = bad_id_q & ~clr_flags_i;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (push_i && full && !pop_i) begin
            overflow_d = 1'b1;
        end
        if (pop_i && empty) begin
            underflow_d = 1'b1;
        end
        if (push_ok && (dest >= NumDrv) && (dest != broadcast)) begin
            bad_id_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ts_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            bad_id_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ts_q        <= ts_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            bad_id_q    <= bad_id_d;
        end
    end

    // Storage is not reset; stale contents are masked by the empty gating below.
    always_ff @(posedge clk_i) begin
        if (push_ok && !reset_i) begin
            data_mem_q[wr_ptr_q] <= d_push_i;
            ts_mem_q[wr_ptr_q]   <= ts_q;
        end
    end

    always_comb begin
        d_pop_o  = '0;
        ts_pop_o = '0;
        if (!empty) begin
            d_pop_o  = data_mem_q[rd_ptr_q];
            ts_pop_o = ts_mem_q[rd_ptr_q];
        end
    end

    assign pndng_o     = ~empty;
    assign full_o      = full;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign bad_id_o    = bad_id_q;
    assign ts_now_o    = ts_q;

endmodule

// File: tb/tb_bus_ts_fifo.sv
// Bench for bus_ts_fifo: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the FIFO.
module tb_bus_ts_fifo;

    localparam int Depth = 16;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        push_i = 1'b0;
    logic [31:0] d_push_i = '0;
    logic        pop_i = 1'b0;
    logic        clr_flags_i = 1'b0;
    logic [31:0] d_pop_o;
    logic [31:0] ts_pop_o;
    logic        pndng_o;
    logic        full_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        bad_id_o;
    logic [31:0] ts_now_o;

    bus_ts_fifo #(
        .width(32), .profundidad(Depth), .ts_width(32), .drivers(2), .broadcast(8'hFF)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .push_i(push_i), .d_push_i(d_push_i),
        .pop_i(pop_i), .d_pop_o(d_pop_o), .ts_pop_o(ts_pop_o), .pndng_o(pndng_o),
        .full_o(full_o), .count_o(count_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .bad_id_o(bad_id_o), .clr_flags_i(clr_flags_i),
        .ts_now_o(ts_now_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] q_data[$];
    logic [31:0] q_ts[$];
    logic [31:0] m_ts;
    logic        m_ovf, m_unf, m_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_ts.delete();
        m_ts  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_bad = 1'b0;
    endtask

    task automatic check_all();
        logic [31:0] hd;
        logic [31:0] ht;
        hd = (q_data.size() != 0) ? q_data[0] : 32'h0;
        ht = (q_ts.size() != 0) ? q_ts[0] : 32'h0;
        chk("count", 64'(count_o), 64'(q_data.size()));
        chk("pndng", 64'(pndng_o), 64'(q_data.size() != 0));
        chk("full", 64'(full_o), 64'(q_data.size() == Depth));
        chk("d_pop", 64'(d_pop_o), 64'(hd));
        chk("ts_pop", 64'(ts_pop_o), 64'(ht));
        chk("ts_now", 64'(ts_now_o), 64'(m_ts));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("underflow", 64'(underflow_o), 64'(m_unf));
        chk("bad_id", 64'(bad_id_o), 64'(m_bad));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check.
    task automatic cyc(input logic p, input logic [31:0] d, input logic po, input logic clr);
        int  n;
        bit  was_full, was_empty, pop_act, push_act;
        logic [7:0] dest;
        push_i = p; d_push_i = d; pop_i = po; clr_flags_i = clr;
        @(posedge clk_i);
        n = q_data.size();
        was_full  = (n == Depth);
        was_empty = (n == 0);
        pop_act   = po && !was_empty;
        push_act  = p && (!was_full || po);
        dest      = d[31:24];
        if (clr) begin
            m_ovf = 1'b0; m_unf = 1'b0; m_bad = 1'b0;
        end
        if (p && was_full && !po) m_ovf = 1'b1;
        if (po && was_empty) m_unf = 1'b1;
        if (push_act && dest >= 8'd2 && dest != 8'hFF) m_bad = 1'b1;
        if (pop_act) begin
            void'(q_data.pop_front());
            void'(q_ts.pop_front());
        end
        if (push_act) begin
            q_data.push_back(d);
            q_ts.push_back(m_ts);
        end
        m_ts = m_ts + 32'd1;
        #1;
        push_i = 1'b0; pop_i = 1'b0; clr_flags_i = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Asserted between edges: outputs must clear before any clock edge.
    task automatic async_reset();
        reset_i = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        reset_i = 1'b0;
        #1;
        check_all();
    endtask

    logic [31:0] rnd_word;
    logic [31:0] t_first;

    initial begin
        model_reset();
        #3;
        async_reset();

        // Push into empty after 5 idle cycles: head shows up one edge later.
        idle(5);
        chk("ts_now_at_push", 64'(ts_now_o), 64'd5);
        cyc(1'b1, 32'h02000001, 1'b0, 1'b0);
        chk("first_head", 64'(d_pop_o), 64'h02000001);
        chk("first_ts", 64'(ts_pop_o), 64'd5);
        chk("first_count", 64'(count_o), 64'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Two pushes 10 cycles apart, then pop both in order.
        cyc(1'b1, 32'h02000001, 1'b0, 1'b0);
        t_first = ts_pop_o;
        idle(9);
        cyc(1'b1, 32'h02000002, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("second_head", 64'(d_pop_o), 64'h02000002);
        chk("ts_delta", 64'(ts_pop_o - t_first), 64'd10);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained_pndng", 64'(pndng_o), 64'd0);
        chk("drained_data", 64'(d_pop_o), 64'd0);

        // Fill, overflow, push+pop while full, drain.
        for (int i = 0; i < Depth; i++) cyc(1'b1, 32'h00000100 + 32'(i), 1'b0, 1'b0);
        chk("full_flag", 64'(full_o), 64'd1);
        cyc(1'b1, 32'h0000DEAD, 1'b0, 1'b0);
        chk("overflow_set", 64'(overflow_o), 64'd1);
        chk("overflow_count", 64'(count_o), 64'd16);
        cyc(1'b1, 32'h0100BEEF, 1'b1, 1'b0);
        chk("full_stays", 64'(full_o), 64'd1);
        for (int i = 0; i < Depth - 1; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("last_out", 64'(d_pop_o), 64'h0100BEEF);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);

        // Underflow and flag clearing.
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("underflow_set", 64'(underflow_o), 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("underflow_clr", 64'(underflow_o), 64'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        chk("set_wins", 64'(underflow_o), 64'd1);
        // Push+pop on empty: only the push acts.
        cyc(1'b1, 32'h01000077, 1'b1, 1'b1);
        chk("empty_pushpop_count", 64'(count_o), 64'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);

        // Destination check.
        cyc(1'b1, 32'h05000000, 1'b0, 1'b0);
        chk("bad_id_set", 64'(bad_id_o), 64'd1);
        cyc(1'b1, 32'hFF000000, 1'b0, 1'b1);
        chk("broadcast_ok", 64'(bad_id_o), 64'd0);
        chk("both_stored", 64'(count_o), 64'd2);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h01000010 + 32'(i), 1'b0, 1'b0);
        async_reset();
        chk("reset_count", 64'(count_o), 64'd0);
        idle(2);
        chk("ts_restart", 64'(ts_now_o), 64'd2);
        cyc(1'b1, 32'h00ABCDEF, 1'b0, 1'b0);
        chk("sole_entry", 64'(count_o), 64'd1);
        chk("sole_head", 64'(d_pop_o), 64'h00ABCDEF);

        // Random traffic: push-biased phase then pop-biased phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 250; i++) begin
                logic p, po, clr;
                logic [7:0] dsel;
                p   = ($urandom_range(0, 99) < (ph == 0 ? 70 : 30));
                po  = ($urandom_range(0, 99) < (ph == 0 ? 35 : 70));
                clr = ($urandom_range(0, 15) == 0);
                case ($urandom_range(0, 4))
                    0: dsel = 8'h00;
                    1: dsel = 8'h01;
                    2: dsel = 8'hFF;
                    3: dsel = 8'h02;
                    default: dsel = 8'($urandom);
                endcase
                rnd_word = {dsel, 24'($urandom)};
                cyc(p, rnd_word, po, clr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
